ram_fifo_hs: RTL
================

RAM_FIFO_HS -- requirements
Module: ram_fifo_hs

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning the entry width in bits.
REQ-002 The block SHALL have parameter LOG2_DEPTH, default 3, meaning DEPTH = 2**LOG2_DEPTH entries.
REQ-003 The block SHALL have parameter AFULL_THRESH, default DEPTH-1, meaning the almost_full_o level.
REQ-004 The block SHALL have parameter AEMPTY_THRESH, default 1, meaning the almost_empty_o level.
REQ-005 The block SHALL have port clk  in  1  clock; all logic rising-edge.
REQ-006 The block SHALL have port reset_n  in  1  reset, synchronous, active-low.
REQ-007 The block SHALL have port flush_i  in  1  synchronous discard of all contents.
REQ-008 The block SHALL have port s_valid_i  in  1  write-side valid.
REQ-009 The block SHALL have port s_ready_o  out  1  write-side ready.
REQ-010 The block SHALL have port s_data_i  in  DATA_WIDTH  write data.
REQ-011 The block SHALL have port m_valid_o  out  1  read-side valid.
REQ-012 The block SHALL have port m_ready_i  in  1  read-side ready.
REQ-013 The block SHALL have port m_data_o  out  DATA_WIDTH  head-of-queue data (first-word-fall-through).
REQ-014 The block SHALL have port count_o  out  LOG2_DEPTH+1  current occupancy.
REQ-015 The block SHALL have port almost_full_o  out  1, asserted when count_o >= AFULL_THRESH.
REQ-016 The block SHALL have port almost_empty_o  out  1, asserted when count_o <= AEMPTY_THRESH.

Function
REQ-017 A push SHALL occur on a rising edge with s_valid_i & s_ready_o; a pop SHALL occur with m_valid_o & m_ready_i.
REQ-018 s_ready_o SHALL equal reset_n & ~flush_i & (count_o != DEPTH), combinationally.
REQ-019 m_valid_o SHALL equal (count_o != 0), registered-derived, with no combinational path from any input.
REQ-020 m_data_o SHALL equal mem[rptr] combinationally; first-word latency SHALL be 1 cycle (data pushed at edge N visible with m_valid_o from cycle N+1).
REQ-021 Write and read pointers SHALL be LOG2_DEPTH bits and wrap modulo DEPTH without special-casing.
REQ-022 count_o SHALL be +1 on push only, -1 on pop only, and unchanged on a simultaneous push and pop.
REQ-023 Simultaneous push and pop SHALL be legal at any occupancy 1..DEPTH-1; when full only a pop occurs; when empty only a push occurs (no bypass).
REQ-024 s_valid_i while full SHALL be ignored with contents unchanged; m_ready_i while empty SHALL be ignored.
REQ-025 flush_i SHALL zero the pointers and count_o at the edge, override any concurrent push/pop, and leave mem contents unchanged.
REQ-026 Data order SHALL be strict FIFO; no entry SHALL be lost or duplicated across wrap-around.

Reset
REQ-027 While reset_n is low at an edge, pointers SHALL be 0, count_o 0, and all mem entries 0.
REQ-028 After reset, m_valid_o=0, m_data_o=0, almost_empty_o=1, almost_full_o=0; s_ready_o SHALL be 0 while reset_n is low and 1 after it is released.
REQ-029 Reset asserted mid-operation SHALL discard all entries at that edge regardless of concurrent handshakes.

Configuration
REQ-030 Macro RAM_FIFO_HS_ERR_FLAGS_EN SHALL, when defined, add ports overflow_o (out 1), underflow_o (out 1) and err_clr_i (in 1).
REQ-031 With the macro defined, overflow_o SHALL set on an edge with s_valid_i high while full, and underflow_o SHALL set on an edge with m_ready_i high while empty.
REQ-032 With the macro defined, both flags SHALL be sticky until err_clr_i (set wins when set and clear coincide), reset to 0, and be unaffected by flush_i.
REQ-033 Without the macro, those ports and their logic SHALL be absent and all other behaviour SHALL be identical.

Verification (DATA_WIDTH=8, LOG2_DEPTH=2, AFULL_THRESH=3, AEMPTY_THRESH=1)
REQ-034 Reset, then push 0xA1 -> next cycle m_valid_o=1, m_data_o=0xA1, count_o=1, almost_empty_o=1.
REQ-035 Push 0x01..0x04 with m_ready_i=0 -> count_o=4, s_ready_o=0, almost_full_o=1 from count 3; a 5th push of 0x05 is dropped; pops return 01,02,03,04.
REQ-036 Continuous push and pop at count 2 over 10 cycles (pointers wrap twice) -> count_o stays 2 and output sequence equals input sequence.
REQ-037 Assert flush_i at count 3 with a concurrent push of 0x55 -> next cycle count_o=0, m_valid_o=0; 0x55 is never output.
REQ-038 With RAM_FIFO_HS_ERR_FLAGS_EN: push when full -> overflow_o=1 until err_clr_i; pop when empty -> underflow_o=1; err_clr_i=1 in the same cycle as a new overflow -> overflow_o stays 1.
REQ-039 Assert reset_n=0 at count 2 during a push/pop -> next cycle count_o=0, m_data_o=0, s_ready_o=0 while reset is held.

Source files
------------

// File: rtl/ram_fifo_hs.sv
// rtl/ram_fifo_hs.sv - first-word-fall-through RAM FIFO with valid/ready handshakes
// Optional sticky overflow/underflow flags are enabled by defining RAM_FIFO_HS_ERR_FLAGS_EN.
module ram_fifo_hs #(
  parameter int DATA_WIDTH    = 8,
  parameter int LOG2_DEPTH    = 3,
  parameter int AFULL_THRESH  = (1 << LOG2_DEPTH) - 1,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic [LOG2_DEPTH:0]   count_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o
`ifdef RAM_FIFO_HS_ERR_FLAGS_EN
  ,
  output logic                  overflow_o,
  output logic                  underflow_o,
  input  logic                  err_clr_i
`endif
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam logic [LOG2_DEPTH:0]   FULL_LVL   = DEPTH[LOG2_DEPTH:0];
  localparam logic [LOG2_DEPTH:0]   AFULL_LVL  = AFULL_THRESH[LOG2_DEPTH:0];
  localparam logic [LOG2_DEPTH:0]   AEMPTY_LVL = AEMPTY_THRESH[LOG2_DEPTH:0];
  localparam logic [LOG2_DEPTH-1:0] PTR_ONE    = 1;
  localparam logic [LOG2_DEPTH:0]   CNT_ONE    = 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [LOG2_DEPTH-1:0] wptr;
  logic [LOG2_DEPTH-1:0] rptr;
  logic [LOG2_DEPTH:0]   count;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;

  assign full           = (count == FULL_LVL);
  assign empty          = (count == '0);
  assign s_ready_o      = reset_n & ~flush_i & ~full;
  assign m_valid_o      = ~empty;
  assign m_data_o       = mem[rptr];
  assign count_o        = count;
  assign almost_full_o  = (count >= AFULL_LVL);
  assign almost_empty_o = (count <= AEMPTY_LVL);
  assign push           = s_valid_i & s_ready_o;
  assign pop            = m_valid_o & m_ready_i;

  // Reset clears storage so the head reads zero afterwards; flush only rewinds pointers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= s_data_i;
        wptr      <= wptr + PTR_ONE;
      end
      if (pop) begin
        rptr <= rptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

`ifdef RAM_FIFO_HS_ERR_FLAGS_EN
  // Set has priority over clear so an error in the clearing cycle is not lost.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (s_valid_i && full) begin
        overflow_o <= 1'b1;
      end else if (err_clr_i) begin
        overflow_o <= 1'b0;
      end
      if (m_ready_i && empty) begin
        underflow_o <= 1'b1;
      end else if (err_clr_i) begin
        underflow_o <= 1'b0;
      end
    end
  end
`endif

endmodule
